conv_window_buffer: RTL

//  Parametrised KERNEL x KERNEL sliding-window generator for the convolution data mover.

---
 rtl/conv_window_buffer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_window_buffer.sv
// conv_window_buffer
//   KERNEL x KERNEL sliding-window generator for the convolution data mover.
//   A raster-order pixel stream is accepted with no backpressure. KERNEL-1
//   shift-line buffers, each IMG_W deep, hold the previous image lines. Once
//   the window lies fully inside the frame, one window is emitted per accepted
//   pixel, tagged with its top-left row/col. The last window of the frame
//   carries a one-cycle frame_done.
//
//   Ports
//     clk, rst       clock (rising edge), asynchronous active-high reset
//     clear          synchronous frame abort; wins over a pixel in the same cycle
//     in_valid       pixel on data_i is accepted when high
//     data_i         pixel, raster order
//     window_o       elem (i,j) at [(i*KERNEL+j)*DATA_WIDTH +: DATA_WIDTH]
//     window_valid   window_o / win_row / win_col valid this cycle
//     win_row        top-left row of the window
//     win_col        top-left col of the window
//     frame_done     one-cycle pulse with the last window of the frame
//     busy           frame in progress (state != IDLE)
//
//   Build option
//     OUT_REG_EN  adds an output register stage on window_o, window_valid,
//                 win_row, win_col and frame_done (latency 2 instead of 1).

// One image line as a shift register. Its output is the pixel that entered
// DEPTH acceptances ago, i.e. the same column of the previous line.
module conv_line_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 14
) (
  input  logic          clk,
  input  logic          shift_en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DEPTH-1:0][DW-1:0] mem;

  // Contents are don't-care after reset: rows that are not yet refilled are
  // never windowed, so no reset is needed here.
  always_ff @(posedge clk)
    if (shift_en) mem <= {mem[DEPTH-2:0], din};

  assign dout = mem[DEPTH-1];
endmodule

module conv_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int KERNEL     = 3,
  parameter int IMG_W      = 14,
  parameter int IMG_H      = 14
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clear,
  input  logic                                in_valid,
  input  logic [DATA_WIDTH-1:0]               data_i,
  output logic [KERNEL*KERNEL*DATA_WIDTH-1:0] window_o,
  output logic                                window_valid,
  output logic [$clog2(IMG_H)-1:0]            win_row,
  output logic [$clog2(IMG_W)-1:0]            win_col,
  output logic                                frame_done,
  output logic                                busy
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int NL = KERNEL - 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] KM1_R    = RW'(KERNEL - 1);
  localparam logic [CW-1:0] KM1_C    = CW'(KERNEL - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t        state;
  logic [RW-1:0] row_cnt, row_nxt, row_tag;
  logic [CW-1:0] col_cnt, col_nxt, col_tag;
  logic          col_last, row_last, frame_end, win_hit;
  logic          vld_q, done_q;
  logic          accept;

  // Packed [i][j] layout lands elem (i,j) at (i*KERNEL+j)*DATA_WIDTH.
  logic [KERNEL-1:0][KERNEL-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [NL-1:0][DATA_WIDTH-1:0]                 lb_out;

  // clear wins over a pixel presented in the same cycle.
  assign accept = in_valid & ~clear;

  // Line chain: line 0 takes the new pixel, line k takes line k-1's output,
  // so line k delivers the pixel k+1 rows above the incoming one.
  for (genvar k = 0; k < NL; k++) begin : g_line
    logic [DATA_WIDTH-1:0] din;
    if (k == 0) begin : g_head
      assign din = data_i;
    end else begin : g_tail
      assign din = lb_out[k-1];
    end
    conv_line_buffer #(.DW(DATA_WIDTH), .DEPTH(IMG_W)) u_line (
      .clk      (clk),
      .shift_en (accept),
      .din      (din),
      .dout     (lb_out[k])
    );
  end

  // Window shifts left one column; new right column is oldest line on top,
  // incoming pixel at the bottom.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < KERNEL; i++)
      for (int j = 0; j < KERNEL-1; j++)
        win_d[i][j] = win_q[i][j+1];
    for (int i = 0; i < KERNEL-1; i++)
      win_d[i][KERNEL-1] = lb_out[KERNEL-2-i];
    win_d[KERNEL-1][KERNEL-1] = data_i;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)         win_q <= '0;
    else if (accept) win_q <= win_d;

  always_comb begin
    col_last  = (col_cnt == COL_LAST);
    row_last  = (row_cnt == ROW_LAST);
    frame_end = col_last & row_last;
    col_nxt   = col_last ? '0 : col_cnt + 1'b1;
    row_nxt   = col_last ? (row_last ? '0 : row_cnt + 1'b1) : row_cnt;
    // Column condition keeps windows from straddling a line wrap.
    win_hit   = (row_cnt >= KM1_R) & (col_cnt >= KM1_C);
  end

  // Counters, FSM and window tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
      row_tag <= '0;
      col_tag <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear) begin
      // Frame abort: window data and tags hold, line buffers untouched.
      state   <= IDLE;
      busy    <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept) begin
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
      vld_q   <= win_hit;
      done_q  <= frame_end;
      if (win_hit) begin
        row_tag <= row_cnt - KM1_R;
        col_tag <= col_cnt - KM1_C;
      end
      case (state)
        IDLE: begin
          state <= (row_nxt >= KM1_R) ? RUN : FILL;
          busy  <= 1'b1;
        end
        FILL: begin
          if (row_nxt >= KM1_R) state <= RUN;
          busy <= 1'b1;
        end
        RUN: begin
          if (frame_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end else begin
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end
  end

`ifdef OUT_REG_EN
  // Extra output stage. The data registers follow win_q every cycle; since
  // win_q only moves on acceptance, the output still holds while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_o     <= '0;
      window_valid <= 1'b0;
      win_row      <= '0;
      win_col      <= '0;
      frame_done   <= 1'b0;
    end else begin
      window_o <= win_q;
      win_row  <= row_tag;
      win_col  <= col_tag;
      if (clear) begin
        window_valid <= 1'b0;
        frame_done   <= 1'b0;
      end else begin
        window_valid <= vld_q;
        frame_done   <= done_q;
      end
    end
  end
`else
  assign window_o     = win_q;
  assign window_valid = vld_q;
  assign win_row      = row_tag;
  assign win_col      = col_tag;
  assign frame_done   = done_q;
`endif

endmodule
